// File: rtl/linear_seq_ctrl.sv
// Sequencer for the fully-connected linear datapath: parameter load, activation stream, result capture.
// Optional watchdog (o_timeout port + 16-bit counter) enabled by defining LINEAR_SEQ_CTRL_TIMEOUT_EN.
module linear_seq_ctrl #(
    parameter int WIDTH        = 16,
    parameter int IN_FEATURES  = 96,
    parameter int OUT_FEATURES = 32,
    parameter int PADDR_W      = 16,
    localparam int WA_W = ($clog2(OUT_FEATURES*IN_FEATURES) > 0) ? $clog2(OUT_FEATURES*IN_FEATURES) : 1,
    localparam int OA_W = ($clog2(OUT_FEATURES) > 0) ? $clog2(OUT_FEATURES) : 1,
    localparam int IA_W = ($clog2(IN_FEATURES) > 0) ? $clog2(IN_FEATURES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_reload,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pmem_req,
    output logic [PADDR_W-1:0] o_pmem_addr,
    input  logic               i_pmem_ack,
    input  logic [WIDTH-1:0]   i_pmem_rdata,
    output logic               o_lin_en,
    output logic               o_lin_weight_load_en,
    output logic [WA_W-1:0]    o_lin_weight_addr,
    output logic [WIDTH-1:0]   o_lin_weight_data,
    output logic               o_lin_bias_load_en,
    output logic [OA_W-1:0]    o_lin_bias_addr,
    output logic [WIDTH-1:0]   o_lin_bias_data,
    output logic               o_lin_valid_in,
    output logic [IA_W-1:0]    o_lin_input_addr,
    output logic [WIDTH-1:0]   o_lin_data_in,
    input  logic               i_lin_valid_out,
    input  logic [OA_W-1:0]    i_lin_output_addr,
    input  logic [WIDTH-1:0]   i_lin_data_out,
    output logic               o_feat_rd_en,
    output logic [IA_W-1:0]    o_feat_addr,
    input  logic [WIDTH-1:0]   i_feat_rdata,
`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
    output logic               o_timeout,
`endif
    output logic               o_res_we,
    output logic [OA_W-1:0]    o_res_addr,
    output logic [WIDTH-1:0]   o_res_data
);

    localparam logic [PADDR_W-1:0] B_BASE   = PADDR_W'(OUT_FEATURES*IN_FEATURES);
    localparam logic [PADDR_W-1:0] LAST_W   = PADDR_W'(OUT_FEATURES*IN_FEATURES - 1);
    localparam logic [PADDR_W-1:0] LAST_B   = PADDR_W'(OUT_FEATURES*IN_FEATURES + OUT_FEATURES - 1);
    localparam logic [IA_W-1:0]    LAST_IN  = IA_W'(IN_FEATURES - 1);
    localparam logic [OA_W-1:0]    LAST_OUT = OA_W'(OUT_FEATURES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD_W, ST_LOAD_B, ST_ARM, ST_STREAM, ST_COMPUTE, ST_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy, r_done, r_params_loaded;
    logic               r_pmem_req;
    logic [PADDR_W-1:0] r_pmem_addr;
    logic               r_lin_en;
    logic               r_w_ld, r_b_ld;
    logic [WA_W-1:0]    r_w_addr;
    logic [OA_W-1:0]    r_b_addr;
    logic [WIDTH-1:0]   r_w_data, r_b_data;
    logic               r_vin;
    logic [IA_W-1:0]    r_in_addr;
    logic [WIDTH-1:0]   r_din;
    logic               r_feat_rd;
    logic [IA_W-1:0]    r_feat_addr;
    logic               r_rd_vld;
    logic [IA_W-1:0]    r_rd_idx;
    logic               r_res_we;
    logic [OA_W-1:0]    r_res_addr;
    logic [WIDTH-1:0]   r_res_data;
    logic [OA_W-1:0]    r_exp_idx;
`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
    logic [15:0]        r_wdog;
    logic               r_timeout;
`endif

    // The datapath holds lin_valid_out between results, so only the next expected index is taken.
    logic w_capture;
    assign w_capture = (r_state == ST_COMPUTE) && i_lin_valid_out && (i_lin_output_addr == r_exp_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_params_loaded <= 1'b0;
            r_pmem_req      <= 1'b0;
            r_pmem_addr     <= '0;
            r_lin_en        <= 1'b0;
            r_w_ld          <= 1'b0;
            r_w_addr        <= '0;
            r_w_data        <= '0;
            r_b_ld          <= 1'b0;
            r_b_addr        <= '0;
            r_b_data        <= '0;
            r_vin           <= 1'b0;
            r_in_addr       <= '0;
            r_din           <= '0;
            r_feat_rd       <= 1'b0;
            r_feat_addr     <= '0;
            r_rd_vld        <= 1'b0;
            r_rd_idx        <= '0;
            r_res_we        <= 1'b0;
            r_res_addr      <= '0;
            r_res_data      <= '0;
            r_exp_idx       <= '0;
`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
            r_wdog          <= '0;
            r_timeout       <= 1'b0;
`endif
        end else begin
            r_w_ld   <= 1'b0;
            r_b_ld   <= 1'b0;
            r_vin    <= 1'b0;
            r_res_we <= 1'b0;
            r_done   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_reload || !r_params_loaded) begin
                            r_state         <= ST_LOAD_W;
                            r_params_loaded <= 1'b0;
                            r_pmem_req      <= 1'b1;
                            r_pmem_addr     <= '0;
                        end else begin
                            r_state   <= ST_ARM;
                            r_lin_en  <= 1'b1;
                            r_vin     <= 1'b1;
                            r_in_addr <= '0;
                            r_din     <= '0;
                        end
                    end
                end

                // One word in flight: ack -> load strobe next cycle -> next request the cycle after.
                ST_LOAD_W, ST_LOAD_B: begin
                    if (r_pmem_req && i_pmem_ack) begin
                        r_pmem_req <= 1'b0;
                        if (r_state == ST_LOAD_W) begin
                            r_w_ld   <= 1'b1;
                            r_w_addr <= WA_W'(r_pmem_addr);
                            r_w_data <= i_pmem_rdata;
                            if (r_pmem_addr == LAST_W)
                                r_state <= ST_LOAD_B;
                        end else begin
                            r_b_ld   <= 1'b1;
                            r_b_addr <= OA_W'(r_pmem_addr - B_BASE);
                            r_b_data <= i_pmem_rdata;
                        end
                    end
                    if (r_w_ld || r_b_ld) begin
                        if (r_b_ld && (r_pmem_addr == LAST_B)) begin
                            r_params_loaded <= 1'b1;
                            r_state         <= ST_ARM;
                            r_lin_en        <= 1'b1;
                            r_vin           <= 1'b1;
                            r_in_addr       <= '0;
                            r_din           <= '0;
                        end else begin
                            r_pmem_req  <= 1'b1;
                            r_pmem_addr <= r_pmem_addr + PADDR_W'(1);
                        end
                    end
                end

                ST_ARM: begin
                    r_state     <= ST_STREAM;
                    r_feat_rd   <= 1'b1;
                    r_feat_addr <= '0;
                    r_rd_vld    <= 1'b0;
                end

                // Read pipe: feat_rd_en at k, rdata at k+1, registered beat visible at k+2.
                ST_STREAM: begin
                    r_rd_vld <= r_feat_rd;
                    r_rd_idx <= r_feat_addr;
                    if (r_feat_rd) begin
                        if (r_feat_addr == LAST_IN)
                            r_feat_rd <= 1'b0;
                        else
                            r_feat_addr <= r_feat_addr + IA_W'(1);
                    end
                    if (r_rd_vld) begin
                        r_vin     <= 1'b1;
                        r_in_addr <= r_rd_idx;
                        r_din     <= i_feat_rdata;
                    end
                    if (r_vin && (r_in_addr == LAST_IN)) begin
                        r_state     <= ST_COMPUTE;
                        r_feat_addr <= '0;
                    end
                end

                ST_COMPUTE: begin
                    if (w_capture) begin
                        r_res_we   <= 1'b1;
                        r_res_addr <= r_exp_idx;
                        r_res_data <= i_lin_data_out;
                        if (r_exp_idx == LAST_OUT) begin
                            r_exp_idx <= '0;
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_lin_en  <= 1'b0;
                        end else begin
                            r_exp_idx <= r_exp_idx + OA_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_exp_idx <= '0;
                end

                default: r_state <= ST_IDLE;
            endcase

`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
            // Watchdog abort overrides the state update above.
            r_timeout <= 1'b0;
            if (r_state inside {ST_LOAD_W, ST_LOAD_B, ST_COMPUTE}) begin
                if (i_pmem_ack || w_capture) begin
                    r_wdog <= '0;
                end else if (r_wdog == 16'hFFFF) begin
                    r_wdog          <= '0;
                    r_timeout       <= 1'b1;
                    r_state         <= ST_IDLE;
                    r_busy          <= 1'b0;
                    r_done          <= 1'b0;
                    r_params_loaded <= 1'b0;
                    r_pmem_req      <= 1'b0;
                    r_pmem_addr     <= '0;
                    r_lin_en        <= 1'b0;
                    r_w_ld          <= 1'b0;
                    r_b_ld          <= 1'b0;
                    r_vin           <= 1'b0;
                    r_res_we        <= 1'b0;
                    r_exp_idx       <= '0;
                end else begin
                    r_wdog <= r_wdog + 16'd1;
                end
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_pmem_req           = r_pmem_req;
    assign o_pmem_addr          = r_pmem_addr;
    assign o_lin_en             = r_lin_en;
    assign o_lin_weight_load_en = r_w_ld;
    assign o_lin_weight_addr    = r_w_addr;
    assign o_lin_weight_data    = r_w_data;
    assign o_lin_bias_load_en   = r_b_ld;
    assign o_lin_bias_addr      = r_b_addr;
    assign o_lin_bias_data      = r_b_data;
    assign o_lin_valid_in       = r_vin;
    assign o_lin_input_addr     = r_in_addr;
    assign o_lin_data_in        = r_din;
    assign o_feat_rd_en         = r_feat_rd;
    assign o_feat_addr          = r_feat_addr;
    assign o_res_we             = r_res_we;
    assign o_res_addr           = r_res_addr;
    assign o_res_data           = r_res_data;
`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
    assign o_timeout            = r_timeout;
`endif

endmodule

// File: tb/tb_linear_seq_ctrl.sv
// Scoreboard bench for linear_seq_ctrl (IN=4, OUT=2): pmem, feature buffer and datapath modelled here.
module tb_linear_seq_ctrl;
    localparam int W = 16, IN = 4, OUT = 2, PW = 16;
    localparam int WA = 3, OA = 1, IA = 2;
    localparam int NW = OUT*IN + OUT;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic i_start = 0, i_reload = 0;
    logic o_busy, o_done, o_pmem_req;
    logic [PW-1:0] o_pmem_addr;
    logic i_pmem_ack;
    logic [W-1:0] i_pmem_rdata;
    logic o_lin_en, o_lin_weight_load_en, o_lin_bias_load_en, o_lin_valid_in;
    logic [WA-1:0] o_lin_weight_addr;
    logic [OA-1:0] o_lin_bias_addr;
    logic [W-1:0] o_lin_weight_data, o_lin_bias_data, o_lin_data_in;
    logic [IA-1:0] o_lin_input_addr;
    logic i_lin_valid_out = 0;
    logic [OA-1:0] i_lin_output_addr = '0;
    logic [W-1:0] i_lin_data_out = '0;
    logic o_feat_rd_en;
    logic [IA-1:0] o_feat_addr;
    logic [W-1:0] i_feat_rdata;
    logic o_res_we;
    logic [OA-1:0] o_res_addr;
    logic [W-1:0] o_res_data;
    logic tmo;

    linear_seq_ctrl #(.WIDTH(W), .IN_FEATURES(IN), .OUT_FEATURES(OUT), .PADDR_W(PW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_reload(i_reload),
        .o_busy(o_busy), .o_done(o_done),
        .o_pmem_req(o_pmem_req), .o_pmem_addr(o_pmem_addr),
        .i_pmem_ack(i_pmem_ack), .i_pmem_rdata(i_pmem_rdata),
        .o_lin_en(o_lin_en),
        .o_lin_weight_load_en(o_lin_weight_load_en), .o_lin_weight_addr(o_lin_weight_addr),
        .o_lin_weight_data(o_lin_weight_data),
        .o_lin_bias_load_en(o_lin_bias_load_en), .o_lin_bias_addr(o_lin_bias_addr),
        .o_lin_bias_data(o_lin_bias_data),
        .o_lin_valid_in(o_lin_valid_in), .o_lin_input_addr(o_lin_input_addr),
        .o_lin_data_in(o_lin_data_in),
        .i_lin_valid_out(i_lin_valid_out), .i_lin_output_addr(i_lin_output_addr),
        .i_lin_data_out(i_lin_data_out),
        .o_feat_rd_en(o_feat_rd_en), .o_feat_addr(o_feat_addr), .i_feat_rdata(i_feat_rdata),
`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
        .o_timeout(tmo),
`endif
        .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data)
    );
`ifndef LINEAR_SEQ_CTRL_TIMEOUT_EN
    assign tmo = 1'b0;
`endif

    logic [98:0] outs;
    assign outs = {tmo, o_busy, o_done, o_pmem_req, o_pmem_addr, o_lin_en,
                   o_lin_weight_load_en, o_lin_weight_addr, o_lin_weight_data,
                   o_lin_bias_load_en, o_lin_bias_addr, o_lin_bias_data,
                   o_lin_valid_in, o_lin_input_addr, o_lin_data_in,
                   o_feat_rd_en, o_feat_addr, o_res_we, o_res_addr, o_res_data};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Scoreboard queues: {addr[15:0], data[15:0]}
    logic [31:0] wq[$], bq[$], vq[$], rq[$];

    // Parameter memory responder
    logic [W-1:0] pmem [0:NW-1];
    int ack_dly [0:NW-1];
    int ack_cnt = 0, exp_paddr = 0, pa;
    bit ack_en = 1, spur_ack = 0;
    initial begin
        i_pmem_ack = 0; i_pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            i_pmem_ack = spur_ack;
            i_pmem_rdata = spur_ack ? 16'hdead : '0;
            if (!o_pmem_req) begin
                ack_cnt = 0;
            end else if (ack_en) begin
                pa = int'(o_pmem_addr);
                if (pa >= NW) pa = 0;
                if (ack_cnt >= ack_dly[pa]) begin
                    chk("paddr_seq", o_pmem_addr, exp_paddr);
                    if (pa < OUT*IN) wq.push_back({16'(pa), pmem[pa]});
                    else             bq.push_back({16'(pa - OUT*IN), pmem[pa]});
                    exp_paddr++;
                    ack_cnt = 0;
                    i_pmem_ack = 1;
                    i_pmem_rdata = pmem[pa];
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    // Feature buffer: data returns the cycle after the read
    logic [W-1:0] feat [0:IN-1];
    bit fpend = 0;
    int fa = 0;
    initial begin
        i_feat_rdata = '0;
        forever begin
            @(posedge clk); #1;
            i_feat_rdata = fpend ? feat[fa] : '0;
            fpend = o_feat_rd_en;
            fa = int'(o_feat_addr);
            if (fpend) vq.push_back({16'(fa), feat[fa]});
        end
    end

    // Output monitor
    int w_cnt = 0, b_cnt = 0, v_cnt = 0, r_cnt = 0, d_cnt = 0, req_cyc = 0, first_vin = -1;
    bit vin_seen = 0, prev_hold = 0;
    logic [PW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold && !tmo) chk("preq_hold", {o_pmem_req, o_pmem_addr}, {1'b1, prev_addr});
            prev_hold = o_pmem_req && !i_pmem_ack;
            prev_addr = o_pmem_addr;
            if (o_pmem_req) req_cyc++;
            if (o_lin_weight_load_en) begin
                w_cnt++;
                if (wq.size() == 0) chk("w_extra", wq.size(), 1);
                else chk("w_wr", {16'(o_lin_weight_addr), o_lin_weight_data}, wq.pop_front());
            end
            if (o_lin_bias_load_en) begin
                b_cnt++;
                if (bq.size() == 0) chk("b_extra", bq.size(), 1);
                else chk("b_wr", {16'(o_lin_bias_addr), o_lin_bias_data}, bq.pop_front());
            end
            if (o_lin_valid_in) begin
                v_cnt++;
                if (!vin_seen) begin vin_seen = 1; first_vin = cyc; end
                if (vq.size() == 0) chk("v_extra", vq.size(), 1);
                else chk("beat", {16'(o_lin_input_addr), o_lin_data_in}, vq.pop_front());
            end
            if (o_res_we) begin
                r_cnt++;
                if (rq.size() == 0) chk("r_extra", rq.size(), 1);
                else chk("res_wr", {16'(o_res_addr), o_res_data}, rq.pop_front());
            end
            if (o_done) d_cnt++;
        end
    end

    // One inference; mode 0 = results in order, mode 1 = held/duplicate/out-of-order results
    task automatic run_inf(bit reload, int mode, bit exp_load);
        int w0, b0, r0, d0, q0, v0, sc, n;
        logic [W-1:0] d0r, d1r;
        w0 = w_cnt; b0 = b_cnt; r0 = r_cnt; d0 = d_cnt; q0 = req_cyc; v0 = v_cnt;
        for (int i = 0; i < IN; i++) feat[i] = W'($urandom);
        d0r = W'($urandom); d1r = W'($urandom);
        vq.push_back(32'h0);
        vin_seen = 0;
        exp_paddr = 0;
        i_start = 1; i_reload = reload; sc = cyc;
        tick();
        i_start = 0; i_reload = 0;
        n = 0;
        while (v_cnt < v0 + IN + 1 && n < 3000) begin tick(); n++; end
        chk("beats", v_cnt - v0, IN + 1);
        i_lin_valid_out = 1;
        if (mode == 0) begin
            i_lin_output_addr = 0; i_lin_data_out = d0r; rq.push_back({16'd0, d0r}); tick();
            i_lin_output_addr = 1; i_lin_data_out = d1r; rq.push_back({16'd1, d1r}); tick();
        end else begin
            i_lin_output_addr = 1; i_lin_data_out = 16'h1111; tick(2);
            i_lin_output_addr = 0; i_lin_data_out = d0r; rq.push_back({16'd0, d0r}); tick(10);
            i_lin_output_addr = 1; i_lin_data_out = d1r; rq.push_back({16'd1, d1r}); tick(3);
            i_lin_output_addr = 0; i_lin_data_out = 16'h2222; tick(2);
        end
        i_lin_valid_out = 0;
        n = 0;
        while (d_cnt == d0 && n < 100) begin tick(); n++; end
        tick(2);
        chk("busy_after", o_busy, 0);
        chk("lin_en_after", o_lin_en, 0);
        chk("done_cnt", d_cnt - d0, 1);
        chk("res_cnt", r_cnt - r0, OUT);
        chk("rq_left", rq.size(), 0);
        chk("w_cnt", w_cnt - w0, exp_load ? OUT*IN : 0);
        chk("b_cnt", b_cnt - b0, exp_load ? OUT : 0);
        if (!exp_load) begin
            chk("no_req", req_cyc - q0, 0);
            chk("arm_lat", first_vin - sc, 1);
        end
    endtask

    int n, ws;
    initial begin
        for (int i = 0; i < NW; i++) begin pmem[i] = W'($urandom); ack_dly[i] = 1; end
        rst = 1;
        tick(3);
        chk("rst_outs", outs, 0);
        rst = 0;
        tick(2);
        chk("idle_outs", outs, 0);

        // cold start: full load, stream, results
        run_inf(0, 0, 1);

        // spurious ack in IDLE, then a no-reload inference
        ws = w_cnt + b_cnt;
        spur_ack = 1; tick(); spur_ack = 0; tick(3);
        chk("spur_ack", w_cnt + b_cnt - ws, 0);
        run_inf(0, 0, 0);

        // reload with word 3 stalled 5 extra cycles
        ack_dly[3] = 6;
        pmem[3] = W'($urandom);
        run_inf(1, 0, 1);
        ack_dly[3] = 1;

        // held / duplicate / out-of-order datapath results
        run_inf(0, 1, 0);

        // reset during STREAM, then the next start must reload
        vq.push_back(32'h0);
        i_start = 1; tick(); i_start = 0;
        n = 0;
        while (!o_feat_rd_en && n < 50) begin tick(); n++; end
        chk("stream_reached", o_feat_rd_en, 1);
        tick();
        rst = 1; tick();
        chk("rst_mid_outs", outs, 0);
        chk("rst_mid_busy", o_busy, 0);
        rst = 0; tick(2);
        vq.delete();
        run_inf(0, 0, 1);

`ifdef LINEAR_SEQ_CTRL_TIMEOUT_EN
        begin
            int d0;
            bit seen;
            d0 = d_cnt; seen = 0;
            ack_en = 0;
            i_start = 1; i_reload = 1; tick(); i_start = 0; i_reload = 0;
            n = 0;
            while (!seen && n < 70000) begin tick(); n++; if (tmo) seen = 1; end
            chk("tmo_seen", seen, 1);
            chk("tmo_lat", (n >= 65530 && n <= 65540), 1);
            tick();
            chk("tmo_pulse", tmo, 0);
            chk("tmo_busy", o_busy, 0);
            chk("tmo_done", d_cnt - d0, 0);
            ack_en = 1;
            wq.delete();
            tick(2);
            run_inf(0, 0, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
